// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MEM->WB pipeline register slice.
//   - Control-bit positions inside the ctrl field (MemtoReg, RegWrite).
//   - Index of the ARMv8 zero register (XZR), whose writes are dropped.
//   - Default payload widths and the default-size writeback entry layout.
//   - Skid-stage state encoding, which is exactly {skid_valid, main_valid}.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int XZR_IDX       = 31;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CTRL_W = 2;

  // The encoding doubles as the pair of valid bits held by the two entry
  // registers, so the state never has to be stored separately. 2'b10 (skid
  // holding data while main is empty) cannot be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } skid_state_e;

  // Default-size entry layout. Parametrised instances build an identically
  // ordered struct from their own widths.
  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_REG_W-1:0]  wreg;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] read_data;
  } wb_entry_t;

endpackage

// File: rtl/skid_entry_reg.sv
// ---------------------------------------------------------------------------
// skid_entry_reg
// One valid bit plus a payload register. A load captures data_in and sets
// valid; a clear drops valid but leaves the payload untouched, so outputs do
// not toggle on squash. Reset is synchronous and zeroes everything.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high; wins over load/clear
//   load      in   capture data_in and mark valid (wins over clear)
//   clear     in   mark invalid, keep payload
//   data_in   in   [W] payload to capture
//   valid_out out  registered valid
//   data_out  out  [W] registered payload
// ---------------------------------------------------------------------------
module skid_entry_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] data_in,
  output logic         valid_out,
  output logic [W-1:0] data_out
);

  logic         valid_d;
  logic         valid_q;
  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Payload only moves on a load, which keeps the register quiet while the
  // stage is stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/pipe_wb_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_wb_skid_stage
// MEM->WB pipeline register with a valid/ready handshake and a two-entry skid
// buffer. in_ready depends only on registered state (plus reset), so a WB
// stall never forms a combinational path back into MEM. Flush squashes both
// entries; writes to the zero register have RegWrite masked off.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   flush                squash all held entries and any offered input
//   in_valid / in_ready  MEM-side handshake
//   read_data_in, alu_result_in, write_register_in, ctrl_in  MEM payload
//   out_valid / out_ready WB-side handshake
//   read_data_out, alu_result_out, write_register_out, ctrl_out  held payload
//   wb_data              MemtoReg-selected writeback value
// ---------------------------------------------------------------------------
module pipe_wb_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int ZERO_REG = XZR_IDX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_W-1:0]  write_register_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_W-1:0]  write_register_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] wb_data
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  entry_t      in_entry;
  entry_t      main_entry;
  entry_t      skid_entry;
  entry_t      main_load_data;
  logic        main_valid;
  logic        skid_valid;
  logic        main_load;
  logic        main_clear;
  logic        main_from_skid;
  logic        skid_load;
  logic        skid_clear;
  logic        in_xfer;
  logic        out_xfer;
  skid_state_e state;

  always_comb begin
    in_entry.ctrl       = ctrl_in;
    in_entry.wreg       = write_register_in;
    in_entry.alu_result = alu_result_in;
    in_entry.read_data  = read_data_in;
  end

  assign in_ready  = ~skid_valid & ~reset;
  assign out_valid = main_valid;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state = skid_state_e'({skid_valid, main_valid});
  end

  // Next-state logic, expressed as load/clear strobes for the two entry
  // registers. Flush beats every transfer; reset is handled inside the
  // entry registers and beats flush.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_xfer && in_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            main_clear = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the drain of skid into main can
          // happen; that keeps strict FIFO order.
          if (out_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_load_data = main_from_skid ? skid_entry : in_entry;

  skid_entry_reg #(
    .W(ENTRY_W)
  ) u_main (
    .clock     (clock),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .data_in   (main_load_data),
    .valid_out (main_valid),
    .data_out  (main_entry)
  );

  skid_entry_reg #(
    .W(ENTRY_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .data_in   (in_entry),
    .valid_out (skid_valid),
    .data_out  (skid_entry)
  );

  assign read_data_out      = main_entry.read_data;
  assign alu_result_out     = main_entry.alu_result;
  assign write_register_out = main_entry.wreg;

  // RegWrite is qualified here so WB can use it without looking at
  // out_valid; every other control bit passes straight through.
  always_comb begin
    ctrl_out                = main_entry.ctrl;
    ctrl_out[CTRL_REGWRITE] = main_entry.ctrl[CTRL_REGWRITE] & main_valid &
                              (main_entry.wreg != ZERO_IDX);
  end

  assign wb_data = main_entry.ctrl[CTRL_MEMTOREG] ? main_entry.read_data
                                                  : main_entry.alu_result;

endmodule

// File: doc/pipe_wb_skid_stage.md
Name: pipe_wb_skid_stage

Overview:
- Parametrised MEM->WB pipeline register for the ARMv8 pipeline.
- Generalises the plain clocked MEM/WB latch: configurable data, register-index and control widths, and a valid/ready handshake.
- A 2-entry skid buffer lets the writeback side stall without a combinational ready path back into MEM.
- Synchronous flush squashes in-flight entries. Writes targeting the zero register (XZR) are suppressed.

Parameters:
DATA_W, 64, width of read_data and alu_result payloads
REG_W, 5, width of destination register index
CTRL_W, 2, width of control field; bit0 = MemtoReg, bit1 = RegWrite, upper bits pass through
ZERO_REG, 31, register index whose writes are suppressed (XZR)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
flush  in  1  squash all held entries this edge
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  stage can accept (registered, = ~skid_valid & ~reset)
read_data_in  in  DATA_W  memory load data
alu_result_in  in  DATA_W  ALU result
write_register_in  in  REG_W  destination register
ctrl_in  in  CTRL_W  control bits
out_valid  out  1  entry presented to WB
out_ready  in  1  WB consumes entry
read_data_out  out  DATA_W  held load data
alu_result_out  out  DATA_W  held ALU result
write_register_out  out  REG_W  held destination
ctrl_out  out  CTRL_W  held control; bit1 gated as below
wb_data  out  DATA_W  ctrl_out[0] ? read_data_out : alu_result_out (combinational mux)

Behaviour:
- Clock and reset: one clock `clock`; `reset` is synchronous and active-high. All state updates on the rising edge.
- Reset: main and skid entries cleared (valid = 0, all payload = 0). Outputs all 0, including out_valid, ctrl_out, write_register_out, data outputs and wb_data. in_ready = 0 while reset is high; 1 on the first cycle after.
- Transfer rules: an input transfer happens when in_valid & in_ready; an output transfer when out_valid & out_ready.
- State is encoded by {skid_valid, main_valid}:
  - EMPTY (00): input transfer -> main <= input; go to FULL.
  - FULL (01):
    - out xfer, no in xfer -> EMPTY.
    - out xfer and in xfer -> main <= input; stay FULL.
    - in xfer, no out xfer -> skid <= input; go to SKID.
    - Neither -> hold.
  - SKID (11): in_ready = 0. On out xfer -> main <= skid; go to FULL. Otherwise hold.
- Latency: 1 cycle from input acceptance to out_valid. Throughput: 1 entry/cycle when out_ready is held high.
- Ordering is strictly FIFO; the skid entry is never presented before main.
- Flush:
  - Priority over all transfers; next state is EMPTY regardless of in_valid and out_ready.
  - An input offered in the flush cycle is discarded.
  - Payload registers may keep stale values, but out_valid = 0 next cycle.
- Flush and reset asserted together: reset wins (payload zeroed).
- Reset mid-operation: entries are lost; no partial write is presented.
- Write suppression: ctrl_out[1] = main_ctrl[1] & main_valid & (main_wreg != ZERO_REG). ctrl_out[0] and upper bits come directly from main.
- When out_valid = 0, payload outputs hold their last value. Consumers must qualify with out_valid; the RegWrite bit is already qualified.
- Payload registers load only on the transfers above, so there is no toggling while stalled.

Decomposition:
- Shared package pipe_pkg:
  - Constants CTRL_MEMTOREG = 0, CTRL_REGWRITE = 1, XZR_IDX = 31.
  - Packed typedef wb_entry_t {ctrl, wreg, alu_result, read_data}, sized from the parameters.
- One natural sub-module: skid_entry_reg, a single valid + payload register with load and clear, instantiated twice (main, skid).
- FSM and write-suppression gating live in the top module.

Test Plan:
- Reset, then stream: out_ready = 1; push 4 entries alu = 1..4, wreg = 2, ctrl = 2'b10 on consecutive cycles -> out_valid high from cycle 1 to cycle 4, alu_result_out = 1,2,3,4 on consecutive cycles, wb_data = alu value, ctrl_out[1] = 1.
- Back-pressure:
  - out_ready = 0; push A (alu = 0xA), then B (0xB) -> in_ready drops after B is accepted; out shows A.
  - Raise out_ready -> A, then B on the next cycle; in_ready returns to 1 one cycle after B moves to main.
- Flush in SKID state: while holding A and B, assert flush with in_valid = 1 (C) -> next cycle out_valid = 0, in_ready = 1; C never appears.
- XZR suppression: push wreg = 31, ctrl = 2'b11, read_data = 0x55 -> out_valid = 1, ctrl_out[1] = 0, wb_data = 0x55. Then wreg = 30 -> ctrl_out[1] = 1.
- Reset mid-stall: in SKID state, assert reset for 1 cycle -> all outputs 0 and in_ready = 0 during reset; in_ready = 1 after; no stale entry is emitted.
- Parametrisation: DATA_W = 32, REG_W = 4, ZERO_REG = 15 -> the stream and suppression scenarios pass with scaled values.
